panel_write_arbiter: RTL and testbench

PANEL_WRITE_ARBITER -- requirements
Module: panel_write_arbiter

---
 rtl/panel_pkg.sv | 11 +
 rtl/panel_arb_timeout.sv | 23 ++
 rtl/panel_write_arbiter.sv | 118 +++++++++++
 tb/tb_panel_write_arbiter.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/panel_pkg.sv
// panel_pkg: shared widths and arbiter state encoding for the panel write path
package panel_pkg;
    localparam int PANEL_EN_W   = 8;
    localparam int PANEL_ADDR_W = 16;
    localparam int PANEL_DATA_W = 24;
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GRANT0 = 2'd1,
        ST_GRANT1 = 2'd2
    } arb_state_t;
endpackage

// File: rtl/panel_arb_timeout.sv
// panel_arb_timeout: grant-idle counter that flags a forced release
// Ports: clk, reset_n (async active-low); clear zeroes the count, idle advances it;
//        expire is high in the idle cycle that reaches TIMEOUT_CYCLES-1
module panel_arb_timeout #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic idle,
    output logic expire
);
    logic [15:0] count;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            count <= '0;
        else if (clear)
            count <= '0;
        else if (idle)
            count <= count + 16'd1;
    end
    assign expire = idle && (count == 16'(TIMEOUT_CYCLES - 1));
endmodule

// File: rtl/panel_write_arbiter.sv
// panel_write_arbiter: burst-locked two-requester arbiter onto the panel write bus
// Ports: clk, reset_n (async active-low); req_valid/req_last/req_ready handshake per
//        requester with reqN_en/addr/wdat words; panel_busy stalls the bus;
//        ctrl_en/addr/wdat registered panel write; grant one-hot owner;
//        timeout_pulse on forced release; stat_* counters.
// Optional: define PANEL_ARB_STATS_EN to build the statistics counters
//           (otherwise the stat ports are tied to zero).
module panel_write_arbiter
    import panel_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [1:0]              req_valid,
    input  logic [1:0]              req_last,
    output logic [1:0]              req_ready,
    input  logic [PANEL_EN_W-1:0]   req0_en,
    input  logic [PANEL_EN_W-1:0]   req1_en,
    input  logic [PANEL_ADDR_W-1:0] req0_addr,
    input  logic [PANEL_ADDR_W-1:0] req1_addr,
    input  logic [PANEL_DATA_W-1:0] req0_wdat,
    input  logic [PANEL_DATA_W-1:0] req1_wdat,
    input  logic                    panel_busy,
    output logic [PANEL_EN_W-1:0]   ctrl_en,
    output logic [PANEL_ADDR_W-1:0] ctrl_addr,
    output logic [PANEL_DATA_W-1:0] ctrl_wdat,
    output logic [1:0]              grant,
    output logic                    timeout_pulse,
    output logic [31:0]             stat_words0,
    output logic [31:0]             stat_words1,
    output logic [15:0]             stat_timeouts
);
    arb_state_t state, state_nxt;
    logic last_grant, last_grant_nxt;
    logic owner, granted, xfer, done, expire;
    logic [1:0] xfer_vec;

    assign owner     = (state == ST_GRANT1);
    assign granted   = (state != ST_IDLE);
    assign grant     = {state == ST_GRANT1, state == ST_GRANT0};
    assign req_ready = grant & {2{~panel_busy}};
    assign xfer_vec  = req_valid & req_ready;
    assign xfer      = |xfer_vec;
    assign done      = |(xfer_vec & req_last);

    panel_arb_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (~granted | xfer),
        .idle    (granted & ~req_valid[owner] & ~panel_busy),
        .expire  (expire)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            last_grant <= 1'b1;
        end else begin
            state      <= state_nxt;
            last_grant <= last_grant_nxt;
        end
    end

    // Ties go to whichever requester did not own the previous burst.
    always_comb begin
        state_nxt      = state;
        last_grant_nxt = last_grant;
        if (state == ST_IDLE) begin
            if (req_valid == 2'b11)
                state_nxt = last_grant ? ST_GRANT0 : ST_GRANT1;
            else if (req_valid[0])
                state_nxt = ST_GRANT0;
            else if (req_valid[1])
                state_nxt = ST_GRANT1;
        end else if (done || expire) begin
            state_nxt      = ST_IDLE;
            last_grant_nxt = owner;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrl_en       <= '0;
            ctrl_addr     <= '0;
            ctrl_wdat     <= '0;
            timeout_pulse <= 1'b0;
        end else begin
            ctrl_en       <= xfer ? (owner ? req1_en : req0_en) : '0;
            timeout_pulse <= expire;
            if (xfer) begin
                ctrl_addr <= owner ? req1_addr : req0_addr;
                ctrl_wdat <= owner ? req1_wdat : req0_wdat;
            end
        end
    end

`ifdef PANEL_ARB_STATS_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stat_words0   <= '0;
            stat_words1   <= '0;
            stat_timeouts <= '0;
        end else begin
            if (xfer_vec[0])
                stat_words0 <= stat_words0 + 32'd1;
            if (xfer_vec[1])
                stat_words1 <= stat_words1 + 32'd1;
            if (expire && stat_timeouts != 16'hFFFF)
                stat_timeouts <= stat_timeouts + 16'd1;
        end
    end
`else
    assign stat_words0   = '0;
    assign stat_words1   = '0;
    assign stat_timeouts = '0;
`endif
endmodule

// File: tb/tb_panel_write_arbiter.sv
// tb_panel_write_arbiter: directed self-checking bench for panel_write_arbiter
module tb_panel_write_arbiter;
`ifdef PANEL_ARB_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  valid = '0, last = '0, ready, grant;
    logic [7:0]  en0 = '0, en1 = '0, ctrl_en;
    logic [15:0] a0 = '0, a1 = '0, ctrl_addr, stat_to;
    logic [23:0] d0 = '0, d1 = '0, ctrl_wdat;
    logic        busy = 1'b0, tpulse;
    logic [31:0] sw0, sw1;
    int tests = 0, failed = 0;

    always #5 clk = ~clk;

    panel_write_arbiter #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .reset_n(reset_n), .req_valid(valid), .req_last(last),
        .req_ready(ready), .req0_en(en0), .req1_en(en1), .req0_addr(a0),
        .req1_addr(a1), .req0_wdat(d0), .req1_wdat(d1), .panel_busy(busy),
        .ctrl_en(ctrl_en), .ctrl_addr(ctrl_addr), .ctrl_wdat(ctrl_wdat),
        .grant(grant), .timeout_pulse(tpulse), .stat_words0(sw0),
        .stat_words1(sw1), .stat_timeouts(stat_to)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        valid = '0;
        last = '0;
        busy = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    initial begin
        do_reset();
        check("rst_grant", grant, 2'b00);
        check("rst_ready", ready, 2'b00);
        check("rst_en", ctrl_en, 8'h00);
        check("rst_addr", ctrl_addr, 16'h0000);
        check("rst_wdat", ctrl_wdat, 24'h000000);
        check("rst_tpulse", tpulse, 1'b0);
        check("rst_stats", sw0 | sw1 | stat_to, 0);

        // req0 burst of three words
        valid = 2'b01; en0 = 8'h0F; a0 = 16'h0010; d0 = 24'h112233;
        step();
        check("a_grant1", grant, 2'b01);
        check("a_ready1", ready, 2'b01);
        check("a_en1", ctrl_en, 8'h00);
        step();
        check("a_en2", ctrl_en, 8'h0F);
        check("a_addr2", ctrl_addr, 16'h0010);
        check("a_wdat2", ctrl_wdat, 24'h112233);
        a0 = 16'h0011;
        step();
        check("a_en3", ctrl_en, 8'h0F);
        check("a_addr3", ctrl_addr, 16'h0011);
        a0 = 16'h0012; last = 2'b01;
        step();
        check("a_en4", ctrl_en, 8'h0F);
        check("a_addr4", ctrl_addr, 16'h0012);
        check("a_grant4", grant, 2'b00);
        valid = '0; last = '0;
        step();
        check("a_en5", ctrl_en, 8'h00);
        check("a_hold5", ctrl_addr, 16'h0012);

        // simultaneous requests from reset
        do_reset();
        valid = 2'b11; en0 = 8'h01; en1 = 8'h02; a0 = 16'h0100; a1 = 16'h0200;
        step();
        check("b_grant1", grant, 2'b01);
        check("b_ready1", ready, 2'b01);
        step();
        check("b_addr2", ctrl_addr, 16'h0100);
        a0 = 16'h0101; last = 2'b01;
        step();
        check("b_addr3", ctrl_addr, 16'h0101);
        check("b_idle3", grant, 2'b00);
        valid = 2'b10; last = '0;
        step();
        check("b_grant4", grant, 2'b10);
        check("b_ready4", ready, 2'b10);
        check("b_en4", ctrl_en, 8'h00);
        step();
        check("b_en5", ctrl_en, 8'h02);
        check("b_addr5", ctrl_addr, 16'h0200);
        a1 = 16'h0201; last = 2'b10;
        step();
        check("b_addr6", ctrl_addr, 16'h0201);
        check("b_idle6", grant, 2'b00);
        valid = 2'b11; last = '0; a0 = 16'h0300; a1 = 16'h0400;
        step();
        check("b_tie7", grant, 2'b01);
        valid = 2'b01; last = 2'b01;
        step();
        check("b_addr8", ctrl_addr, 16'h0300);
        valid = '0; last = '0;
        step();

        // panel_busy stall mid-burst
        valid = 2'b01; en0 = 8'hAA; a0 = 16'h0500;
        step();
        step();
        check("c_addr2", ctrl_addr, 16'h0500);
        a0 = 16'h0501; busy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("c_ready", ready, 2'b00);
            check("c_en", ctrl_en, 8'h00);
            check("c_grant", grant, 2'b01);
            check("c_tpulse", tpulse, 1'b0);
        end
        busy = 1'b0; last = 2'b01;
        step();
        check("c_en_done", ctrl_en, 8'hAA);
        check("c_addr_done", ctrl_addr, 16'h0501);
        check("c_grant_done", grant, 2'b00);
        check("c_tpulse_done", tpulse, 1'b0);
        valid = '0; last = '0;
        step();

        // req1 abandons its burst -> forced release after 4 idle cycles
        valid = 2'b10; en1 = 8'h33; a1 = 16'h0600;
        step();
        check("d_grant1", grant, 2'b10);
        step();
        check("d_addr2", ctrl_addr, 16'h0600);
        valid = '0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("d_hold_grant", grant, 2'b10);
            check("d_no_pulse", tpulse, 1'b0);
        end
        step();
        check("d_release", grant, 2'b00);
        check("d_pulse", tpulse, 1'b1);
        check("d_stat_to", stat_to, STATS ? 16'd1 : 16'd0);
        step();
        check("d_pulse_end", tpulse, 1'b0);

        // zero-enable word still completes the handshake
        valid = 2'b01; last = 2'b01; en0 = 8'h00; a0 = 16'h0777;
        step();
        step();
        check("e_en0", ctrl_en, 8'h00);
        check("e_addr", ctrl_addr, 16'h0777);
        check("e_grant", grant, 2'b00);
        valid = '0; last = '0;

        // statistics: 10 req0 words then 7 req1 words
        do_reset();
        en0 = 8'h01; en1 = 8'h02;
        valid = 2'b01;
        step();
        for (int k = 0; k < 10; k++) begin
            a0 = 16'(k); last = (k == 9) ? 2'b01 : 2'b00;
            step();
            check("f_addr0", ctrl_addr, k);
        end
        valid = 2'b10; last = '0;
        step();
        for (int k = 0; k < 7; k++) begin
            a1 = 16'(16'h100 + k); last = (k == 6) ? 2'b10 : 2'b00;
            step();
            check("f_addr1", ctrl_addr, 16'h100 + k);
        end
        valid = '0; last = '0;
        step();
        check("f_words0", sw0, STATS ? 32'd10 : 32'd0);
        check("f_words1", sw1, STATS ? 32'd7 : 32'd0);
        check("f_timeouts", stat_to, 16'd0);

        // reset in the middle of a req0 burst with req1 pending
        valid = 2'b11; en0 = 8'hFF; en1 = 8'h44; a0 = 16'h0700; a1 = 16'h0800;
        step();
        check("g_grant1", grant, 2'b01);
        step();
        check("g_en2", ctrl_en, 8'hFF);
        reset_n = 1'b0; valid = 2'b10;
        #1;
        check("g_rst_ready", ready, 2'b00);
        check("g_rst_en", ctrl_en, 8'h00);
        check("g_rst_grant", grant, 2'b00);
        @(posedge clk);
        #1 reset_n = 1'b1;
        step();
        check("g_grant_req1", grant, 2'b10);
        check("g_no_strobe", ctrl_en, 8'h00);
        last = 2'b10;
        step();
        check("g_en_req1", ctrl_en, 8'h44);
        check("g_addr_req1", ctrl_addr, 16'h0800);
        valid = '0; last = '0;
        step();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
